// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-programmable pattern of 1..PAT_W bits.
// Overlapping or non-overlapping matching is chosen per sample by 'overlap'; z is a registered
// match pulse one cycle after the completing sample.
// Optional feature macro: SEQDET_CNT_EN builds the saturating match counter and cnt_clr logic;
// when undefined, match_cnt is tied to 0 and cnt_clr is ignored.
module seq_detector_param #(
   parameter int unsigned      PAT_W   = 8,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(8'b0000_0101),
   parameter int unsigned      RST_LEN = 4,
   parameter int unsigned      CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         x,
   input  logic                         x_valid,
   input  logic                         overlap,
   input  logic                         cfg_load,
   input  logic [PAT_W-1:0]             cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
   input  logic                         cnt_clr,
   output logic                         z,
   output logic [CNT_W-1:0]             match_cnt
);

   localparam int unsigned     LenW    = $clog2(PAT_W + 1);
   localparam logic [LenW-1:0] PatWL   = LenW'(PAT_W);
   localparam logic [LenW-1:0] RstLenL = LenW'(RST_LEN);

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LenW-1:0]  fill_q, fill_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LenW-1:0]  len_q, len_d;
   logic             z_q, z_d;

   logic [PAT_W-1:0] hist_n;
   logic [LenW-1:0]  fill_n;
   logic [PAT_W-1:0] len_mask;
   logic             accept;
   logic             match;

   // Match decode on the would-be history; bits at or above len are masked out of the compare.
   always_comb begin
      accept = x_valid & ~cfg_load;
      hist_n = {hist_q[PAT_W-2:0], x};
      fill_n = (fill_q == PatWL) ? PatWL : fill_q + LenW'(1);
      for (int unsigned i = 0; i < PAT_W; i++) begin
         len_mask[i] = (i < 32'(len_q));
      end
      match = accept && (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
   end

   // Next-state: configuration load flushes history, accepted samples shift it in.
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      len_d  = len_q;
      z_d    = match;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         fill_d = '0;
         hist_d = '0;
         if (cfg_len == '0) begin
            len_d = LenW'(1);
         end else if (cfg_len > PatWL) begin
            len_d = PatWL;
         end else begin
            len_d = cfg_len;
         end
      end else if (accept) begin
         hist_d = hist_n;
         // Non-overlapping: keep the bits but require a fresh len samples before the next match.
         fill_d = (match && !overlap) ? '0 : fill_n;
      end
   end

   // Detector state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= PATTERN;
         len_q  <= RstLenL;
         z_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         len_q  <= len_d;
         z_q    <= z_d;
      end
   end

   assign z = z_q;

`ifdef SEQDET_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating match counter; a clear wins over a coincident match.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (match && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register, updated on the same edge as z.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed sequences plus randomized traffic, checked by a
// scoreboard fed from a bit-list reference model. Counter expectations follow SEQDET_CNT_EN.
module tb_seq_detector_param;

   localparam int unsigned PAT_W  = 8;
   localparam int unsigned CNT_W  = 2;
   localparam int          CntMax = (1 << CNT_W) - 1;
   localparam logic [7:0]  RstPat = 8'b0000_0101;
   localparam int          RstLen = 4;

   logic             clk = 1'b0;
   logic             reset, x, x_valid, overlap, cfg_load, cnt_clr;
   logic [PAT_W-1:0] cfg_pattern;
   logic [3:0]       cfg_len;
   logic             z;
   logic [CNT_W-1:0] match_cnt;

   seq_detector_param #(
      .PAT_W  (PAT_W),
      .PATTERN(RstPat),
      .RST_LEN(RstLen),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .x          (x),
      .x_valid    (x_valid),
      .overlap    (overlap),
      .cfg_load   (cfg_load),
      .cfg_pattern(cfg_pattern),
      .cfg_len    (cfg_len),
      .cnt_clr    (cnt_clr),
      .z          (z),
      .match_cnt  (match_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic z;
      int   cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Reference model: list of accepted bits since the last flush, newest at the back.
   bit         m_bits[$];
   logic [7:0] m_pat;
   int         m_len;
   int         m_cnt;

   function automatic exp_t model(input logic r, xi, v, ov, ld, input logic [7:0] p,
                                  input logic [3:0] l, input logic clr);
      exp_t e;
      logic mz = 1'b0;
      if (r) begin
         m_bits.delete();
         m_pat = RstPat;
         m_len = RstLen;
         m_cnt = 0;
      end else begin
         if (ld) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((int'(l) > PAT_W) ? PAT_W : int'(l));
            m_bits.delete();
         end else if (v) begin
            m_bits.push_back(xi);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
               mz = 1'b1;
               for (int k = 0; k < m_len; k++) begin
                  if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) mz = 1'b0;
               end
            end
            if (mz && !ov) m_bits.delete();
         end
`ifdef SEQDET_CNT_EN
         if (clr) m_cnt = 0;
         else if (mz && m_cnt < CntMax) m_cnt++;
`else
         m_cnt = 0;
`endif
      end
      e.z   = mz;
      e.cnt = m_cnt;
      return e;
   endfunction

   // Drive one cycle of stimulus; the expected response is queued once the edge consumes it.
   task automatic step(input logic r, xi, v, ov, ld, input logic [7:0] p,
                       input logic [3:0] l, input logic clr);
      exp_t e;
      reset = r; x = xi; x_valid = v; overlap = ov; cfg_load = ld;
      cfg_pattern = p; cfg_len = l; cnt_clr = clr;
      e = model(r, xi, v, ov, ld, p, l, clr);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic bit_in(input logic xi, input logic ov);
      step(1'b0, xi, 1'b1, ov, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic gap(input logic ov);
      step(1'b0, 1'b0, 1'b0, ov, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd1, 1'b1);
   endtask

   // Direct check of an output against a value stated in the test plan.
   task automatic check_out(input string name, input logic ez, input int ecnt);
      int c;
`ifdef SEQDET_CNT_EN
      c = ecnt;
`else
      c = 0;
`endif
      checks++;
      if (z !== ez || int'(match_cnt) != c) begin
         errors++;
         $display("FAIL %s: got z=%b cnt=%0d, expected z=%b cnt=%0d", name, z, match_cnt, ez, c);
      end
   endtask

   // Monitor: one expected response per clock, compared away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      cycle++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (z !== e.z) begin
            errors++;
            $display("FAIL sb_z cycle %0d: got %b expected %b", cycle, z, e.z);
         end
         checks++;
         if (int'(match_cnt) != e.cnt) begin
            errors++;
            $display("FAIL sb_cnt cycle %0d: got %0d expected %0d", cycle, match_cnt, e.cnt);
         end
      end
   end

   initial begin
      logic [5:0] s;
      logic [7:0] b8;
      reset = 1'b1; x = 1'b0; x_valid = 1'b0; overlap = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cnt_clr = 1'b0;
      @(posedge clk); #1;
      do_reset();
      do_reset();
      check_out("reset_state", 1'b0, 0);

      // Overlapping 010101: pulses after bits 4 and 6.
      s = 6'b010101;
      for (int i = 5; i >= 0; i--) begin
         bit_in(s[i], 1'b1);
         if (i == 2) check_out("ovl_first", 1'b1, 1);
         if (i == 1) check_out("ovl_gap", 1'b0, 1);
      end
      check_out("ovl_second", 1'b1, 2);

      // Non-overlapping: only bit 4, then 0,1 completes a second match.
      do_reset();
      for (int i = 5; i >= 0; i--) bit_in(s[i], 1'b0);
      check_out("novl_one", 1'b0, 1);
      bit_in(1'b0, 1'b0);
      bit_in(1'b1, 1'b0);
      check_out("novl_second", 1'b1, 2);

      // Gaps within the pattern.
      do_reset();
      bit_in(1'b0, 1'b1); gap(1'b1); bit_in(1'b1, 1'b1); gap(1'b1); gap(1'b1);
      bit_in(1'b0, 1'b1); check_out("gap_partial", 1'b0, 0);
      bit_in(1'b1, 1'b1); check_out("gap_match", 1'b1, 1);
      gap(1'b1); check_out("gap_pulse_end", 1'b0, 1);

      // Reconfigure to 8'hA5, length 8.
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd8, 1'b0);
      check_out("cfg_cycle", 1'b0, 0);
      b8 = 8'hA5;
      for (int i = 7; i >= 0; i--) bit_in(b8[i], 1'b1);
      check_out("cfg_a5", 1'b1, 1);
      for (int i = 3; i >= 0; i--) bit_in(s[i], 1'b1);
      check_out("cfg_old_pat", 1'b0, 1);

      // Length 0 clamps to 1; pattern bit0=1 matches every valid 1; counter saturates.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bit_in(1'b1, 1'b1);
         check_out("len1_pulse", 1'b1, (i + 2 > CntMax) ? CntMax : i + 2);
      end
      bit_in(1'b1, 1'b1);
      check_out("cnt_sat", 1'b1, CntMax);

      // Clear coincident with a match: clear wins, z still pulses.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
      check_out("clr_vs_match", 1'b1, 0);

      // Length above PAT_W clamps to PAT_W.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd15, 1'b0);
      for (int i = 7; i >= 0; i--) bit_in(b8[i], 1'b1);
      check_out("len_clamp", 1'b1, 1);

      // Reset mid-match discards the partial 0,1,0.
      do_reset();
      bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
      do_reset();
      bit_in(1'b1, 1'b1); check_out("rst_discard", 1'b0, 0);
      for (int i = 3; i >= 0; i--) bit_in(s[i], 1'b1);
      check_out("rst_full", 1'b1, 1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         logic       r, ld, clr;
         logic [7:0] p;
         logic [3:0] l;
         r   = ($urandom_range(99) == 0);
         ld  = ($urandom_range(49) == 0);
         clr = ($urandom_range(29) == 0);
         p   = 8'($urandom);
         l   = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(1, 3));
         step(r, 1'($urandom), ($urandom_range(3) != 0), ($urandom_range(7) != 0), ld, p, l, clr);
      end
      x_valid = 1'b0; cfg_load = 1'b0; reset = 1'b0; cnt_clr = 1'b0;

      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, the successor to the fixed 4-bit "0101" Mealy detector. It compares a 1-bit serial stream against a runtime-programmable pattern of 1..PAT_W bits, with overlapping or non-overlapping matching selected by an input. It also provides a qualified input strobe and an optional saturating match counter. It sits on serial receive paths wherever a framing or sync word has to be found.

## Interface
- PAT_W, 8, maximum pattern length in bits (2..32)
- PATTERN, 8'b0000_0101, reset-time pattern; the low PAT_W bits are used
- RST_LEN, 4, reset-time active pattern length (1..PAT_W)
- CNT_W, 8, width of the match counter

- clk  in  1  sole clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- x  in  1  serial data bit
- x_valid  in  1  x is sampled only in cycles where this is 1
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_load  in  1  load cfg_pattern/cfg_len and flush the history
- cfg_pattern  in  PAT_W  new pattern; bit [len-1] is received first
- cfg_len  in  $clog2(PAT_W+1)  new active length
- cnt_clr  in  1  clear the match counter
- z  out  1  registered match pulse
- match_cnt  out  CNT_W  number of matches, saturating

## Operation
- State:
  - hist[PAT_W-1:0]: shift register; the newest bit enters at bit 0.
  - fill: number of valid history bits, 0..PAT_W, saturating at PAT_W.
  - pat, len: active configuration.
- Accepted sample: a cycle with x_valid=1 and cfg_load=0.
  - hist_n = {hist[PAT_W-2:0], x}
  - fill_n = min(fill+1, PAT_W)
- Match condition: accepted sample AND fill_n >= len AND hist_n[len-1:0] == pat[len-1:0]. Bits above len are ignored.
- On a match:
  - overlap=1: hist and fill update normally, so a suffix of this match can start the next one.
  - overlap=0: fill <= 0. History bits are kept but are ignored until fill reaches len again.
- overlap is sampled on every accepted sample, so a mode change applies from the next sample.
- cfg_load=1:
  - pat <= cfg_pattern; len <= clamp(cfg_len): 0 becomes 1, values above PAT_W become PAT_W.
  - fill <= 0. x is ignored that cycle and z is 0 the next cycle.
- Cycles with x_valid=0 hold hist and fill; the pattern may span gaps of any length.
- Counter: increments on each match and saturates at 2^CNT_W-1.
  - cnt_clr=1 forces match_cnt to 0. When a clear and a match fall in the same cycle, the clear wins and the result is 0.
- Reset (reset=1 at a rising edge):
  - hist=0, fill=0, pat=PATTERN, len=RST_LEN, z=0, match_cnt=0.
  - Reset overrides cfg_load, cnt_clr and x_valid. Reset in the middle of a partial match discards it.

## Timing
- z is a one-cycle pulse in the cycle after the accepted sample that completes a match (registered Mealy, latency 1). It is high in consecutive cycles only if matches occur on consecutive accepted samples.
- match_cnt is updated in the same edge as z, so it reflects the match together with z.
- A new configuration applies to the first accepted sample after the cfg_load cycle. A full len accepted samples are needed before the next possible match.
- There is no combinational path from any input to any output.

## Configuration
- SEQDET_CNT_EN:
  - Defined: the match counter and cnt_clr logic are built as described above.
  - Undefined: match_cnt is tied to 0, cnt_clr is ignored, and no counter flops are inferred.
- z behaviour is identical either way.

## Test plan
- Reset defaults (len=4, pattern 0101): the stream 0,1,0,1,0,1 on consecutive valid cycles with overlap=1 gives z high after the 4th and 6th bits; match_cnt=2.
- Same stream with overlap=0: z high only after the 4th bit; match_cnt=1. Adding 0,1 after it gives a second pulse after the 8th bit.
- Gaps: 0,_,1,_,_,0,1 (where _ means x_valid=0) gives a single z pulse one cycle after the final valid bit.
- Reconfiguration: cfg_load with cfg_pattern=8'hA5, cfg_len=8, then stream 10100101 followed by 0101 gives one pulse for 8'hA5 and none for the old pattern. cfg_len=0 behaves as length 1; then x=1 with pattern bit0=1 pulses on every valid cycle.
- Counter, CNT_W=2:
  - Five matches give match_cnt=3 (saturated).
  - cnt_clr in the same cycle as a match gives match_cnt=0 while z still pulses.
  - With SEQDET_CNT_EN undefined, match_cnt stays 0.
- Reset after 0,1,0 has been received, then a single 1: no z. The full 0,1,0,1 is then required to match.
